cbfp_denorm: RTL and testbench
==============================

Name: cbfp_denorm

Overview:
- Inverse of the FFT CBFP normalizer. Accepts 11-bit normalized mantissas, 16 lanes per clock, for re and im, plus per-block shift exponents (leading-zero counts). Restores each sample to the common DOUT_SIZE fixed-point scale.
- Sits at the FFT output / reorder stage, where blocks normalized with different exponents must be re-aligned before comparison or accumulation.
- Each block is BEATS beats of ARRAY_SIZE lanes (4 x 16 = 64 samples).

Parameters:
- ARRAY_SIZE, 16, lanes per beat
- BEATS, 4, beats per CBFP block
- DIN_SIZE, 11, normalized mantissa width (signed)
- DOUT_SIZE, 23, restored sample width (signed)
- EXP_SIZE, 5, exponent (zero-count) width
- SHIFT_BASE, 12, normalizer truncation offset (its DIN - DOUT)

Ports:
- clk  input  1  clock
- rstn  input  1  async active-low reset
- valid_in  input  1  input beat valid
- sop_in  input  1  first beat of block; qualified by valid_in
- exp_re  input  EXP_SIZE  block exponent, real path; sampled only on valid_in&&sop_in
- exp_im  input  EXP_SIZE  block exponent, imag path; sampled only on valid_in&&sop_in
- din_re  input  [DIN_SIZE-1:0] x ARRAY_SIZE, signed  real mantissas
- din_im  input  [DIN_SIZE-1:0] x ARRAY_SIZE, signed  imag mantissas
- dout_re  output  [DOUT_SIZE-1:0] x ARRAY_SIZE, signed  restored real
- dout_im  output  [DOUT_SIZE-1:0] x ARRAY_SIZE, signed  restored imag
- valid_out  output  1  output beat valid
- sop_out  output  1  first output beat of block
- err_sync  output  1  one-cycle pulse on framing error

Behaviour:
- Interface: clock clk; reset rstn, asynchronous, active-low. No backpressure; the block accepts every valid beat.
- Reset values: dout_re/dout_im all 0; valid_out, sop_out, err_sync 0; FSM IDLE; beat_cnt 0; latched exponents 0. Reset mid-block discards the partial block and the in-flight pipeline.
- FSM states: IDLE, RUN.
  - IDLE, valid_in&&sop_in: latch exp_re/exp_im, process the beat, beat_cnt=1, go to RUN. (If BEATS==1, stay in IDLE.)
  - IDLE, valid_in&&!sop_in: beat dropped (no valid_out), err_sync pulses.
  - RUN, valid_in&&!sop_in: process the beat, beat_cnt++. On the beat where beat_cnt==BEATS-1: beat_cnt=0, go to IDLE.
  - RUN, valid_in&&sop_in: err_sync pulses; the partial block is abandoned (beats already issued are not recalled). The new block starts: latch new exponents, process the beat as the first beat, beat_cnt=1.
  - valid_in low: hold all state. Gaps of any length are allowed mid-block.
- Pipeline, latency 2 cycles from an accepted beat to valid_out. A beat accepted at cycle t appears at t+2.
  - Stage 1 registers lanes, the exponent in use, and the sop flag.
  - Stage 2 computes shift/saturation and registers dout.
  - sop_out is asserted with the output beat derived from a sop beat.
  - Back-to-back beats give back-to-back valid_out.
  - dout holds its last value when valid_out=0.
- err_sync is registered: asserted the cycle after the offending beat, for one cycle.
- Arithmetic, per lane, re uses exp_re and im uses exp_im:
  - s = SHIFT_BASE - exp (signed, EXP_SIZE+2 bits).
  - s >= 0: sign-extend din to DOUT_SIZE, then arithmetic left shift by s.
  - s < 0: arithmetic right shift by -s, floor/truncate. A shift >= DOUT_SIZE yields 0 or -1 (sign fill).
  - Result saturates to the signed DOUT_SIZE range [-2^(DOUT_SIZE-1), 2^(DOUT_SIZE-1)-1] if the left shift overflows. No overflow is possible with default parameters; saturation is required for generality.

Optional Feature:
- Macro CBFP_DENORM_ROUND_EN.
- Defined: for s < 0, add 2^(-s-1) before the right shift (round half up), computed at DOUT_SIZE+1 bits and then saturated.
- Undefined: plain truncation toward -inf.
- Left-shift path and latency are unchanged in both cases.

Test Plan:
- Unity scale: exp_re=12 (s=0), din_re[0]=100, din_re[1]=-1 -> dout_re[0]=100, dout_re[1]=-1, valid_out at t+2.
- Max expansion: exp_re=0 (s=12), din_re[0]=1023, din_re[1]=-1024 -> dout_re[0]=4190208, dout_re[1]=-4194304; exp_im=5 with din_im[0]=-3 -> dout_im[0]=-384.
- Right shift: exp_re=15 (s=-3), din_re[0]=13, din_re[1]=-5 -> truncate gives 1 and -1; with CBFP_DENORM_ROUND_EN gives 2 and -1.
- Framing with a gap: sop at t, beats at t, t+1, a gap at t+2, beats at t+3, t+4 -> valid_out at t+2, t+3, t+5, t+6; sop_out only at t+2; exponent held for all 4 beats, even if exp_in changes on non-sop beats.
- Errors: valid without sop in IDLE -> no valid_out, err_sync=1 one cycle later. sop on the 3rd beat of a block -> err_sync pulse, new exponent applied from that beat, 4 more beats needed before IDLE.
- Reset mid-block: rstn low after 2 beats -> all outputs 0 immediately. Next beat without sop -> dropped with err_sync.

Source files
------------

// File: rtl/cbfp_denorm_if.sv
// Beat bus for the CBFP de-normalizer: normalized lanes in, restored lanes out.
interface cbfp_denorm_if #(
   parameter int ARRAY_SIZE = 16,
   parameter int DIN_SIZE   = 11,
   parameter int DOUT_SIZE  = 23,
   parameter int EXP_SIZE   = 5
);
   logic                                  valid_in;
   logic                                  sop_in;
   logic [EXP_SIZE-1:0]                   exp_re;
   logic [EXP_SIZE-1:0]                   exp_im;
   logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]   din_re;
   logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]   din_im;
   logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0]  dout_re;
   logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0]  dout_im;
   logic                                  valid_out;
   logic                                  sop_out;
   logic                                  err_sync;

   modport master (
      output valid_in, sop_in, exp_re, exp_im, din_re, din_im,
      input  dout_re, dout_im, valid_out, sop_out, err_sync
   );

   modport slave (
      input  valid_in, sop_in, exp_re, exp_im, din_re, din_im,
      output dout_re, dout_im, valid_out, sop_out, err_sync
   );
endinterface

// File: rtl/cbfp_denorm.sv
// CBFP de-normalizer: re-aligns block-exponent mantissas to a common scale.
// Optional round-half-up on right shifts: define CBFP_DENORM_ROUND_EN.
module cbfp_denorm #(
   parameter int ARRAY_SIZE = 16,
   parameter int BEATS      = 4,
   parameter int DIN_SIZE   = 11,
   parameter int DOUT_SIZE  = 23,
   parameter int EXP_SIZE   = 5,
   parameter int SHIFT_BASE = 12
) (
   input logic          clk,
   input logic          rstn,
   cbfp_denorm_if.slave bus
);

   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SW = EXP_SIZE + 2;
   localparam int LW = DOUT_SIZE + SHIFT_BASE + 2;
   localparam logic signed [LW-1:0] SMAX =
      {{(LW-DOUT_SIZE+1){1'b0}}, {(DOUT_SIZE-1){1'b1}}};
   localparam logic signed [LW-1:0] SMIN = ~SMAX;

   typedef enum logic {IDLE, RUN} state_t;

   typedef logic [ARRAY_SIZE-1:0][DIN_SIZE-1:0]  din_t;
   typedef logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0] dout_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [EXP_SIZE-1:0] er_q, er_d;
   logic [EXP_SIZE-1:0] ei_q, ei_d;

   logic                go_sop;
   logic                go_run;
   logic                acc;
   logic                err_d;
   logic [EXP_SIZE-1:0] er_use;
   logic [EXP_SIZE-1:0] ei_use;

   logic                v1_q;
   logic                s1_q;
   logic [EXP_SIZE-1:0] e1r_q;
   logic [EXP_SIZE-1:0] e1i_q;
   din_t                re1_q;
   din_t                im1_q;

   logic                vo_q;
   logic                so_q;
   logic                err_q;
   dout_t               dre_q, dre_d;
   dout_t               dim_q, dim_d;

   // Wide intermediate keeps left-shift overflow visible to the saturator.
   function automatic logic [DOUT_SIZE-1:0] denorm(
      input logic [DIN_SIZE-1:0] d,
      input logic [EXP_SIZE-1:0] e
   );
      logic signed [SW-1:0] s;
      logic [SW-1:0]        n;
      logic signed [LW-1:0] x;
      s = SW'(SHIFT_BASE) - {2'b00, e};
      n = s[SW-1] ? -s : s;
      x = {{(LW-DIN_SIZE){d[DIN_SIZE-1]}}, d};
      if (!s[SW-1]) begin
         x = x <<< n;
      end else begin
`ifdef CBFP_DENORM_ROUND_EN
         x = x + (LW'(1) << (n - 1'b1));
`endif
         x = x >>> n;
      end
      if (x > SMAX)
         denorm = SMAX[DOUT_SIZE-1:0];
      else if (x < SMIN)
         denorm = SMIN[DOUT_SIZE-1:0];
      else
         denorm = x[DOUT_SIZE-1:0];
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         er_q    <= '0;
         ei_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         er_q    <= er_d;
         ei_q    <= ei_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      er_d    = er_q;
      ei_d    = ei_q;
      unique case (1'b1)
         go_sop: begin
            er_d = bus.exp_re;
            ei_d = bus.exp_im;
            if (BEATS == 1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               state_d = RUN;
               cnt_d   = CW'(1);
            end
         end
         go_run: begin
            if (cnt_q == CW'(BEATS-1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      go_sop = bus.valid_in && bus.sop_in;
      go_run = bus.valid_in && !bus.sop_in && (state_q == RUN);
      acc    = go_sop || go_run;
      err_d  = bus.valid_in &&
               (bus.sop_in ? (state_q == RUN) : (state_q == IDLE));
      er_use = go_sop ? bus.exp_re : er_q;
      ei_use = go_sop ? bus.exp_im : ei_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q  <= 1'b0;
         s1_q  <= 1'b0;
         e1r_q <= '0;
         e1i_q <= '0;
         re1_q <= '0;
         im1_q <= '0;
      end else begin
         v1_q <= acc;
         s1_q <= go_sop;
         if (acc) begin
            e1r_q <= er_use;
            e1i_q <= ei_use;
            re1_q <= bus.din_re;
            im1_q <= bus.din_im;
         end
      end
   end

   always_comb begin
      dre_d = '0;
      dim_d = '0;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         dre_d[i] = denorm(re1_q[i], e1r_q);
         dim_d[i] = denorm(im1_q[i], e1i_q);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vo_q  <= 1'b0;
         so_q  <= 1'b0;
         err_q <= 1'b0;
         dre_q <= '0;
         dim_q <= '0;
      end else begin
         vo_q  <= v1_q;
         so_q  <= v1_q && s1_q;
         err_q <= err_d;
         if (v1_q) begin
            dre_q <= dre_d;
            dim_q <= dim_d;
         end
      end
   end

   assign bus.valid_out = vo_q;
   assign bus.sop_out   = so_q;
   assign bus.err_sync  = err_q;
   assign bus.dout_re   = dre_q;
   assign bus.dout_im   = dim_q;

endmodule

// File: tb/tb_cbfp_denorm.sv
// Directed bench for cbfp_denorm: scaling, framing, errors and reset.
module tb_cbfp_denorm;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;

`ifdef CBFP_DENORM_ROUND_EN
   localparam int R13 = 2;
   localparam int RIM = 0;
`else
   localparam int R13 = 1;
   localparam int RIM = -1;
`endif

   cbfp_denorm_if #(
      .ARRAY_SIZE(16), .DIN_SIZE(11), .DOUT_SIZE(23), .EXP_SIZE(5)
   ) bif ();

   cbfp_denorm #(
      .ARRAY_SIZE(16), .BEATS(4), .DIN_SIZE(11),
      .DOUT_SIZE(23), .EXP_SIZE(5), .SHIFT_BASE(12)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic signed [31:0] got,
                      input logic signed [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   function automatic logic signed [31:0] ore(input int i);
      return 32'($signed(bif.dout_re[i]));
   endfunction

   function automatic logic signed [31:0] oim(input int i);
      return 32'($signed(bif.dout_im[i]));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic sop,
                      input int er, input int ei,
                      input int r0, input int r1, input int i0);
      bif.valid_in  = v;
      bif.sop_in    = sop;
      bif.exp_re    = 5'(er);
      bif.exp_im    = 5'(ei);
      bif.din_re[0] = 11'(r0);
      bif.din_re[1] = 11'(r1);
      bif.din_im[0] = 11'(i0);
      tick();
   endtask

   task automatic idle();
      put(1'b0, 1'b0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bif.valid_in = 1'b0;
      bif.sop_in   = 1'b0;
      bif.exp_re   = '0;
      bif.exp_im   = '0;
      bif.din_re   = '0;
      bif.din_im   = '0;

      tick();
      tick();
      chk("rst_valid", 32'(bif.valid_out), 0);
      chk("rst_sop", 32'(bif.sop_out), 0);
      chk("rst_err", 32'(bif.err_sync), 0);
      chk("rst_re0", ore(0), 0);
      chk("rst_im0", oim(0), 0);
      rstn = 1'b1;
      tick();

      // unity scale; exp_in changes on non-sop beats must be ignored
      put(1, 1, 12, 12, 100, -1, 7);
      chk("unity_lat", 32'(bif.valid_out), 0);
      put(1, 0, 0, 0, 100, -1, 7);
      chk("unity_valid", 32'(bif.valid_out), 1);
      chk("unity_sop", 32'(bif.sop_out), 1);
      chk("unity_re0", ore(0), 100);
      chk("unity_re1", ore(1), -1);
      chk("unity_im0", oim(0), 7);
      put(1, 0, 0, 0, 100, -1, 7);
      chk("unity_sop2", 32'(bif.sop_out), 0);
      chk("unity_hold_exp", ore(0), 100);
      put(1, 0, 0, 0, 100, -1, 7);
      idle();
      chk("unity_last", 32'(bif.valid_out), 1);
      idle();
      chk("unity_done", 32'(bif.valid_out), 0);
      chk("unity_noerr", 32'(bif.err_sync), 0);
      chk("unity_holdout", ore(0), 100);

      // max expansion
      put(1, 1, 0, 5, 1023, -1024, -3);
      put(1, 0, 0, 5, 0, 0, 0);
      chk("max_re0", ore(0), 4190208);
      chk("max_re1", ore(1), -4194304);
      chk("max_im0", oim(0), -384);
      put(1, 0, 0, 5, 0, 0, 0);
      put(1, 0, 0, 5, 0, 0, 0);
      idle();
      idle();

      // right shift, plus full sign-fill on the imag path
      put(1, 1, 15, 31, 13, -5, -3);
      put(1, 0, 0, 0, 0, 0, 0);
      chk("rsh_re0", ore(0), R13);
      chk("rsh_re1", ore(1), -1);
      chk("rsh_im0", oim(0), RIM);
      put(1, 0, 0, 0, 0, 0, 0);
      put(1, 0, 0, 0, 0, 0, 0);
      idle();
      idle();

      // framing with a mid-block gap
      put(1, 1, 12, 12, 1, 0, 0);
      chk("gap_v0", 32'(bif.valid_out), 0);
      put(1, 0, 3, 3, 2, 0, 0);
      chk("gap_v1", 32'(bif.valid_out), 1);
      chk("gap_sop1", 32'(bif.sop_out), 1);
      chk("gap_d1", ore(0), 1);
      idle();
      chk("gap_v2", 32'(bif.valid_out), 1);
      chk("gap_sop2", 32'(bif.sop_out), 0);
      chk("gap_d2", ore(0), 2);
      put(1, 0, 3, 3, 3, 0, 0);
      chk("gap_hole", 32'(bif.valid_out), 0);
      chk("gap_hold", ore(0), 2);
      put(1, 0, 3, 3, 4, 0, 0);
      chk("gap_v3", 32'(bif.valid_out), 1);
      chk("gap_d3", ore(0), 3);
      idle();
      chk("gap_v4", 32'(bif.valid_out), 1);
      chk("gap_d4", ore(0), 4);
      chk("gap_noerr", 32'(bif.err_sync), 0);
      idle();
      chk("gap_end", 32'(bif.valid_out), 0);

      // valid without sop while idle
      put(1, 0, 12, 12, 9, 0, 0);
      chk("drop_err", 32'(bif.err_sync), 1);
      idle();
      chk("drop_nov", 32'(bif.valid_out), 0);
      chk("drop_err1", 32'(bif.err_sync), 0);

      // sop on the third beat restarts the block
      put(1, 1, 12, 12, 5, 0, 0);
      put(1, 0, 12, 12, 6, 0, 0);
      put(1, 1, 11, 12, 7, 0, 0);
      chk("resop_err", 32'(bif.err_sync), 1);
      chk("resop_old", ore(0), 6);
      put(1, 0, 0, 0, 8, 0, 0);
      chk("resop_err1", 32'(bif.err_sync), 0);
      chk("resop_sop", 32'(bif.sop_out), 1);
      chk("resop_d0", ore(0), 14);
      put(1, 0, 0, 0, 9, 0, 0);
      chk("resop_d1", ore(0), 16);
      put(1, 0, 0, 0, 10, 0, 0);
      chk("resop_4th_ok", 32'(bif.err_sync), 0);
      chk("resop_d2", ore(0), 18);
      put(1, 0, 0, 0, 11, 0, 0);
      chk("resop_d3", ore(0), 20);
      chk("resop_5th_err", 32'(bif.err_sync), 1);
      idle();
      chk("resop_drop", 32'(bif.valid_out), 0);
      idle();

      // asynchronous reset mid-block
      put(1, 1, 12, 12, 50, 0, 0);
      put(1, 0, 12, 12, 51, 0, 0);
      chk("mrst_pre", 32'(bif.valid_out), 1);
      bif.valid_in = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("mrst_valid", 32'(bif.valid_out), 0);
      chk("mrst_sop", 32'(bif.sop_out), 0);
      chk("mrst_re0", ore(0), 0);
      tick();
      rstn = 1'b1;
      put(1, 0, 12, 12, 52, 0, 0);
      chk("mrst_err", 32'(bif.err_sync), 1);
      idle();
      chk("mrst_nov", 32'(bif.valid_out), 0);
      idle();
      chk("mrst_quiet", 32'(bif.valid_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
